ubin_accum: RTL and testbench
=============================

UBIN_ACCUM -- requirements
Module: ubin_accum

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8; window length is 2^BITWIDTH sampled bits.
REQ-002 SHALL have port iClk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port iRstN, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port iClr, input, 1 bit: synchronous clear; aborts the window and returns to IDLE.
REQ-005 SHALL have port iStart, input, 1 bit: starts a new accumulation window.
REQ-006 SHALL have port iEn, input, 1 bit: qualifies iBit; iBit is sampled only when iEn=1.
REQ-007 SHALL have port iBit, input, 1 bit: unary bitstream bit, i.e. the multiplier product stream.
REQ-008 SHALL have port iReady, input, 1 bit: consumer ready for the result.
REQ-009 SHALL have port oData, output, BITWIDTH+1 bits: count of ones in the completed window, range 0..2^BITWIDTH.
REQ-010 SHALL have port oValid, output, 1 bit: oData holds a completed result.
REQ-011 SHALL have port oBusy, output, 1 bit: high while in state COUNT.

Function
REQ-012 SHALL implement an FSM with states IDLE, COUNT and HOLD.
REQ-013 IDLE with iStart=1 SHALL clear the ones counter and the length counter and go to COUNT on the next edge.
REQ-014 COUNT with iEn=1 SHALL add iBit to the ones counter and increment the length counter; with iEn=0, both counters SHALL hold.
REQ-015 COUNT SHALL ignore iStart.
REQ-016 When the 2^BITWIDTH-th bit is sampled in COUNT, oData SHALL show the final count including that bit, and oValid SHALL be 1 from the next edge; state goes to HOLD.
REQ-017 Latency from the last sampled bit to oValid SHALL be exactly 1 cycle.
REQ-018 HOLD SHALL keep oData and oValid stable while iReady=0.
REQ-019 HOLD with iReady=1 (the transfer) SHALL go to IDLE and drop oValid on the next edge.
REQ-020 If the transfer and iStart coincide in HOLD, the FSM SHALL go directly to COUNT with cleared counters (back-to-back windows, no idle cycle).
REQ-021 The length counter SHALL be BITWIDTH+1 bits wide and the ones counter BITWIDTH+1 bits wide; neither SHALL wrap within a window.
REQ-022 iClr=1 SHALL take priority over iStart, iEn and iReady in every state: next state IDLE, counters cleared, oValid=0, oData=0.
REQ-023 iBit SHALL be ignored outside COUNT.
REQ-024 oBusy SHALL be 1 exactly when the state is COUNT.

Reset
REQ-025 iRstN=0 SHALL immediately force state IDLE, both counters 0, oData=0, oValid=0 and oBusy=0, including mid-window.
REQ-026 After iRstN deasserts, the block SHALL remain in IDLE until iStart=1.

Structure
REQ-027 A shared package ubin_pkg SHALL hold the FSM state typedef (IDLE, COUNT, HOLD) and the window-length constant function of BITWIDTH.
REQ-028 One sub-module ucnt (BITWIDTH+1-bit up-counter with synchronous clear, enable and increment input) SHALL be instantiated twice: once for ones, once for length.
REQ-029 The implementation SHALL be synthesizable RTL with no latches and no combinational path from iBit to any output.

Verification
REQ-030 BITWIDTH=8, iStart, iEn=1, iBit=1 for 256 cycles -> oValid 1 cycle after the 256th bit, oData=256.
REQ-031 Same stimulus with iBit=0 for 256 cycles -> oData=0; with iBit alternating 1,0 -> oData=128.
REQ-032 256 sampled bits with 64 ones, interleaved with 100 cycles of iEn=0 -> oData=64; oValid rises at cycle 357 after start.
REQ-033 iReady held at 0 for 10 cycles after oValid -> oData unchanged for those 10 cycles; iReady=1 together with iStart -> next window starts with no gap and oBusy=1 on the following cycle.
REQ-034 iClr=1 at sampled bit 100, together with iStart=1 -> IDLE, oValid never asserts, and a fresh window then gives the correct count.
REQ-035 iRstN pulsed low mid-window -> all outputs 0 asynchronously and the block stays in IDLE until iStart.

Source files
------------

// File: rtl/ubin_pkg.sv
// ----------------------------------------------------------------------------
// ubin_pkg
// Shared definitions for the unary-bitstream accumulator:
//   state_e  - accumulator FSM states (IDLE, COUNT, HOLD)
//   win_len  - number of sampled bits in one window for a given BITWIDTH
// ----------------------------------------------------------------------------
package ubin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Window length is 2^bitwidth sampled bits.
    function automatic int unsigned win_len(input int unsigned bitwidth);
        return 32'd1 << bitwidth;
    endfunction

endpackage : ubin_pkg

// File: rtl/ucnt.sv
// ----------------------------------------------------------------------------
// ucnt
// WIDTH-bit up-counter with synchronous clear and a qualified 1-bit increment.
// Ports:
//   iClk   - clock, rising edge
//   iRstN  - asynchronous active-low reset, counter -> 0
//   iClr   - synchronous clear, wins over iEn
//   iEn    - when 1, iInc is added to the count
//   iInc   - increment amount (0 or 1)
//   oCount - current count (registered)
// ----------------------------------------------------------------------------
module ucnt #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iClr,
    input  logic             iEn,
    input  logic             iInc,
    output logic [WIDTH-1:0] oCount
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (iClr) begin
            count_d = '0;
        end else if (iEn) begin
            count_d = count_q + WIDTH'(iInc);
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign oCount = count_q;

endmodule : ucnt

// File: rtl/ubin_accum.sv
// ----------------------------------------------------------------------------
// ubin_accum
// Counts the ones in a window of 2^BITWIDTH qualified bits of a unary
// bitstream (e.g. a stochastic multiplier product) and hands the count to a
// consumer with a valid/ready handshake.
// Ports:
//   iClk   - clock, rising edge
//   iRstN  - asynchronous active-low reset
//   iClr   - synchronous clear, aborts any window, highest priority
//   iStart - start a window (IDLE, or HOLD together with iReady)
//   iEn    - qualifies iBit while counting
//   iBit   - bitstream input
//   iReady - consumer accepts the result while oValid=1
//   oData  - ones count of the completed window, 0..2^BITWIDTH
//   oValid - oData holds a completed result
//   oBusy  - a window is being counted
// ----------------------------------------------------------------------------
module ubin_accum
    import ubin_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iClr,
    input  logic              iStart,
    input  logic              iEn,
    input  logic              iBit,
    input  logic              iReady,
    output logic [BITWIDTH:0] oData,
    output logic              oValid,
    output logic              oBusy
);

    localparam int unsigned CW = BITWIDTH + 1;

    // Length value seen while the final bit of the window is being sampled.
    localparam logic [CW-1:0] LAST_LEN = CW'(win_len(BITWIDTH) - 1);

    state_e          state_d;
    state_e          state_q;
    logic            valid_d;
    logic            valid_q;
    logic            busy_d;
    logic            busy_q;
    logic            cnt_clr;
    logic            cnt_en;
    logic [CW-1:0]   ones_cnt;
    logic [CW-1:0]   len_cnt;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        if (iClr) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (iStart) begin
                        state_d = COUNT;
                        cnt_clr = 1'b1;
                    end
                end
                COUNT: begin
                    // iStart is deliberately not looked at here.
                    if (iEn) begin
                        cnt_en = 1'b1;
                        if (len_cnt == LAST_LEN) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (iReady) begin
                        if (iStart) begin
                            // Back-to-back window: no idle cycle in between.
                            state_d = COUNT;
                            cnt_clr = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state and have no input-to-output
        // combinational path.
        valid_d = (state_d == HOLD);
        busy_d  = (state_d == COUNT);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Ones counter: adds iBit only on qualified cycles in COUNT.
    ucnt #(
        .WIDTH (CW)
    ) u_ones (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iClr   (cnt_clr),
        .iEn    (cnt_en),
        .iInc   (iBit),
        .oCount (ones_cnt)
    );

    // Length counter: counts qualified cycles in COUNT.
    ucnt #(
        .WIDTH (CW)
    ) u_len (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iClr   (cnt_clr),
        .iEn    (cnt_en),
        .iInc   (1'b1),
        .oCount (len_cnt)
    );

    // The ones counter stops moving once the window completes, so it doubles
    // as the result register while oValid is high.
    assign oData  = ones_cnt;
    assign oValid = valid_q;
    assign oBusy  = busy_q;

endmodule : ubin_accum

// File: tb/tb_ubin_accum.sv
// ----------------------------------------------------------------------------
// tb_ubin_accum
// Self-checking bench for ubin_accum (BITWIDTH=8). A window-level model tracks
// whether a window is open, how many bits were taken and how many were ones,
// and a negedge monitor compares oBusy/oValid/oData against it every cycle.
// Directed scenarios add literal expectations for counts and latencies.
// ----------------------------------------------------------------------------
module tb_ubin_accum;

    localparam int BW  = 8;
    localparam int WIN = 256;

    logic          iClk;
    logic          iRstN;
    logic          iClr;
    logic          iStart;
    logic          iEn;
    logic          iBit;
    logic          iReady;
    logic [BW:0]   oData;
    logic          oValid;
    logic          oBusy;

    int n_tests = 0;
    int n_fail  = 0;

    ubin_accum #(
        .BITWIDTH (BW)
    ) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iClr   (iClr),
        .iStart (iStart),
        .iEn    (iEn),
        .iBit   (iBit),
        .iReady (iReady),
        .oData  (oData),
        .oValid (oValid),
        .oBusy  (oBusy)
    );

    initial iClk = 1'b0;
    always #10 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- window-level reference model ----------------
    bit m_busy  = 1'b0;   // a window is open
    bit m_valid = 1'b0;   // a finished result is waiting for the consumer
    bit m_zero  = 1'b1;   // output known to be zero (after reset/clear)
    int m_n     = 0;      // bits taken in the open window
    int m_ones  = 0;      // ones taken in the open window
    int m_data  = 0;      // finished result

    initial forever begin
        @(posedge iClk or negedge iRstN);
        if (!iRstN || iClr) begin
            m_busy = 0; m_valid = 0; m_zero = 1; m_n = 0; m_ones = 0; m_data = 0;
        end else if (m_busy) begin
            if (iEn) begin
                m_n++;
                m_ones += int'(iBit);
            end
            if (m_n == WIN) begin
                m_busy  = 0;
                m_valid = 1;
                m_data  = m_ones;
            end
        end else if (m_valid) begin
            if (iReady) begin
                m_valid = 0;
                if (iStart) begin
                    m_busy = 1; m_zero = 0; m_n = 0; m_ones = 0;
                end
            end
        end else if (iStart) begin
            m_busy = 1; m_zero = 0; m_n = 0; m_ones = 0;
        end
    end

    initial forever begin
        @(negedge iClk);
        check("busy", 32'(oBusy), 32'(m_busy));
        check("valid", 32'(oValid), 32'(m_valid));
        if (m_valid) check("data", 32'(oData), m_data);
        if (m_zero)  check("data_zero", 32'(oData), 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic step(inout int edge_n, inout int v_edge, inout int v_data);
        tick();
        edge_n++;
        if (v_edge < 0 && oValid === 1'b1) begin
            v_edge = edge_n;
            v_data = int'(oData);
        end
    endtask

    function automatic logic pick_bit(input int kind, input int i);
        case (kind)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (i % 2 == 0);
            3:       return (i % 4 == 0);
            default: return 1'($urandom);
        endcase
    endfunction

    task automatic start_window();
        iStart = 1'b1; iEn = 1'($urandom); iBit = 1'($urandom); iReady = 1'b0;
        tick();
        iStart = 1'b0;
    endtask

    // Feeds one full window (window already started; that edge is edge 1),
    // with `gaps` iEn=0 cycles interleaved, then waits briefly for oValid.
    task automatic feed(input int kind, input int gaps,
                        output int v_data, output int v_edge, output int ones);
        int edge_n;
        int gaps_left;
        logic b;
        edge_n = 1; gaps_left = gaps;
        v_data = -1; v_edge = -1; ones = 0;
        for (int i = 0; i < WIN; i++) begin
            if (gaps_left > 0 && (i % 2 == 1)) begin
                iEn = 1'b0; iBit = 1'($urandom); iStart = 1'($urandom); iReady = 1'($urandom);
                step(edge_n, v_edge, v_data);
                gaps_left--;
            end
            b = pick_bit(kind, i);
            iEn = 1'b1; iBit = b; iStart = (kind == 4) ? 1'($urandom) : 1'b0; iReady = 1'b0;
            step(edge_n, v_edge, v_data);
            ones += int'(b);
        end
        iEn = 1'b0; iStart = 1'b0; iReady = 1'b0;
        for (int k = 0; k < 4 && v_edge < 0; k++) step(edge_n, v_edge, v_data);
    endtask

    task automatic hold_check(input int cycles, input int data);
        for (int i = 0; i < cycles; i++) begin
            iReady = 1'b0; iStart = 1'($urandom); iEn = 1'($urandom); iBit = 1'($urandom);
            tick();
            check("hold_data", 32'(oData), data);
            check("hold_valid", 32'(oValid), 1);
        end
    endtask

    task automatic transfer(input logic with_start);
        iReady = 1'b1; iStart = with_start; iEn = 1'($urandom); iBit = 1'($urandom);
        tick();
        iReady = 1'b0; iStart = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int d, e, ones, g;
    bit seen;
    bit b2b;

    initial begin
        iRstN = 1'b0; iClr = 1'b0; iStart = 1'b0; iEn = 1'b0; iBit = 1'b0; iReady = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        check("rst_valid", 32'(oValid), 0);
        check("rst_busy", 32'(oBusy), 0);
        check("rst_data", 32'(oData), 0);
        iRstN = 1'b1;

        // Stays idle without iStart; iBit/iEn/iReady ignored.
        seen = 0;
        repeat (6) begin
            iEn = 1'($urandom); iBit = 1'($urandom); iReady = 1'($urandom);
            tick();
            seen |= oBusy | oValid;
        end
        check("idle_after_reset", 32'(seen), 0);

        // All ones: result 256, valid one cycle after the 256th bit.
        start_window();
        feed(0, 0, d, e, ones);
        check("ones_edge", e, 257);
        check("ones_data", d, 256);
        hold_check(10, 256);
        transfer(1'b1);
        check("b2b_busy", 32'(oBusy), 1);
        check("b2b_valid", 32'(oValid), 0);

        // All zeros, started back-to-back.
        feed(1, 0, d, e, ones);
        check("zeros_edge", e, 257);
        check("zeros_data", d, 0);
        transfer(1'b0);
        check("xfer_idle_valid", 32'(oValid), 0);

        // Alternating 1,0.
        start_window();
        feed(2, 0, d, e, ones);
        check("alt_data", d, 128);
        transfer(1'b0);

        // 64 ones across 256 bits with 100 disabled cycles interleaved.
        start_window();
        feed(3, 100, d, e, ones);
        check("gap_edge", e, 357);
        check("gap_data", d, 64);
        transfer(1'b0);

        // Clear together with start at the 100th sampled bit.
        start_window();
        for (int i = 0; i < 99; i++) begin
            iEn = 1'b1; iBit = 1'($urandom);
            tick();
        end
        iEn = 1'b1; iBit = 1'b1; iClr = 1'b1; iStart = 1'b1;
        tick();
        iClr = 1'b0; iStart = 1'b0;
        check("clr_busy", 32'(oBusy), 0);
        check("clr_valid", 32'(oValid), 0);
        check("clr_data", 32'(oData), 0);
        seen = 0;
        repeat (300) begin
            iEn = 1'($urandom); iBit = 1'($urandom); iReady = 1'($urandom);
            tick();
            seen |= oValid | oBusy;
        end
        iReady = 1'b0;
        check("clr_no_valid", 32'(seen), 0);
        start_window();
        feed(4, 20, d, e, ones);
        check("after_clr_edge", e, 277);
        check("after_clr_data", d, ones);

        // Clear in HOLD beats a simultaneous transfer+start.
        iClr = 1'b1; iReady = 1'b1; iStart = 1'b1;
        tick();
        iClr = 1'b0; iReady = 1'b0; iStart = 1'b0;
        check("hold_clr_valid", 32'(oValid), 0);
        check("hold_clr_busy", 32'(oBusy), 0);
        check("hold_clr_data", 32'(oData), 0);

        // Asynchronous reset in the middle of a window.
        start_window();
        for (int i = 0; i < 50; i++) begin
            iEn = 1'b1; iBit = 1'b1;
            tick();
        end
        #3;
        iRstN = 1'b0;
        #2;
        check("async_rst_busy", 32'(oBusy), 0);
        check("async_rst_valid", 32'(oValid), 0);
        check("async_rst_data", 32'(oData), 0);
        tick();
        iRstN = 1'b1;
        seen = 0;
        repeat (10) begin
            iEn = 1'($urandom); iBit = 1'($urandom); iReady = 1'($urandom);
            tick();
            seen |= oBusy | oValid;
        end
        iReady = 1'b0;
        check("rst_stays_idle", 32'(seen), 0);
        check("rst_idle_data", 32'(oData), 0);
        start_window();
        feed(4, 30, d, e, ones);
        check("after_rst_data", d, ones);
        transfer(1'b0);

        // Random windows with random gaps, hold times and back-to-back starts.
        b2b = 0;
        for (int w = 0; w < 4; w++) begin
            if (!b2b) start_window();
            g = int'($urandom_range(0, 60));
            feed(4, g, d, e, ones);
            check("rand_edge", e, 257 + g);
            check("rand_data", d, ones);
            hold_check(int'($urandom_range(0, 5)), ones);
            b2b = 1'($urandom);
            transfer(b2b);
        end
        if (b2b) begin
            feed(4, 0, d, e, ones);
            check("rand_last_data", d, ones);
            transfer(1'b0);
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

endmodule : tb_ubin_accum
